glitch_sweep: RTL

Sequencer that drives the glitch handler through a two-dimensional parameter sweep of first-delay by pulse-width. For each point it programs the delay and width, issues one RUN_ONCE control write, waits for the attempt to complete, and then advances to the next point. It sits between the register bank and the handler, and takes over the handler's control, delay and pulse-width inputs while it is busy.

---
 rtl/glitch_sweep.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/glitch_sweep.sv
// glitch_sweep: walks the glitch handler through a delay x pulse-width grid.
// For every grid point it programs delay/width, issues one RUN_ONCE write,
// waits for the handler to lock and release, lets the line settle, then moves
// on. Width is the inner loop, delay the outer loop. All outputs are flops.
module glitch_sweep #(
  parameter int SETTLE_CYCLES = 16,
  parameter int ARM_WINDOW    = 4
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_START,
  input  logic        i_ABORT,
  input  logic [31:0] i_DELAY_START,
  input  logic [31:0] i_DELAY_STEP,
  input  logic [15:0] i_DELAY_COUNT,
  input  logic [31:0] i_WIDTH_START,
  input  logic [31:0] i_WIDTH_STEP,
  input  logic [15:0] i_WIDTH_COUNT,
  input  logic        i_MODE_TRIGGER,
  input  logic [31:0] i_TIMEOUT,
  input  logic        i_LOCK,
  input  logic [4:0]  i_HANDLER_STATUS,
  output logic [31:0] o_DELAY_1ST,
  output logic [31:0] o_DELAY_2ND,
  output logic [31:0] o_PULSE_WIDTH,
  output logic [7:0]  o_CONTROL,
  output logic        o_CONTROL_WR,
  output logic        o_BUSY,
  output logic        o_DONE,
  output logic [1:0]  o_RESULT,
  output logic [4:0]  o_HANDLER_ERR,
  output logic [15:0] o_DELAY_IDX,
  output logic [15:0] o_WIDTH_IDX,
  output logic [31:0] o_ATTEMPTS,
  output logic [31:0] o_TIMEOUTS
);

  localparam logic [7:0]  CTRL_STOP     = 8'h00;
  localparam logic [7:0]  CTRL_RUN      = 8'h01;
  localparam logic [7:0]  CTRL_RUN_TRIG = 8'h11;
  localparam logic [31:0] ARM_LAST      = 32'(ARM_WINDOW - 1);
  localparam logic [31:0] SETTLE_LAST   = 32'(SETTLE_CYCLES - 1);

  localparam logic [1:0] RES_OK     = 2'd0;
  localparam logic [1:0] RES_CFG    = 2'd1;
  localparam logic [1:0] RES_REJECT = 2'd2;
  localparam logic [1:0] RES_ABORT  = 2'd3;

  // ABT_GAP exists so an abort arriving right after a write strobe still
  // leaves one idle cycle before the stop strobe (WR never high twice in a row).
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_WRITE, S_ARM, S_RUN, S_STOP_TMO,
    S_SETTLE, S_ABT_GAP, S_STOP_ABT, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] dstep_q, dstep_d;
  logic [31:0] wstart_q, wstart_d;
  logic [31:0] wstep_q, wstep_d;
  logic [15:0] dcnt_q, dcnt_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        mode_q, mode_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] delay_q, delay_d;
  logic [31:0] width_q, width_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic        wr_q, wr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  result_q, result_d;
  logic [4:0]  herr_q, herr_d;
  logic [15:0] didx_q, didx_d;
  logic [15:0] widx_q, widx_d;
  logic [31:0] att_q, att_d;
  logic [31:0] tmocnt_q, tmocnt_d;

  // Next-state and next-output logic for the sweep sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dstep_d  = dstep_q;
    wstart_d = wstart_q;
    wstep_d  = wstep_q;
    dcnt_d   = dcnt_q;
    wcnt_d   = wcnt_q;
    mode_d   = mode_q;
    tmo_d    = tmo_q;
    delay_d  = delay_q;
    width_d  = width_q;
    ctrl_d   = ctrl_q;
    wr_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    herr_d   = herr_q;
    didx_d   = didx_q;
    widx_d   = widx_q;
    att_d    = att_q;
    tmocnt_d = tmocnt_q;

    if (i_ABORT && busy_q && (state_q != S_ABT_GAP) && (state_q != S_STOP_ABT)) begin
      // Abort outranks every other event in a busy state.
      if (wr_q) begin
        state_d = S_ABT_GAP;
      end else begin
        state_d = S_STOP_ABT;
        wr_d    = 1'b1;
        ctrl_d  = CTRL_STOP;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_START && !i_ABORT) begin
            dstep_d  = i_DELAY_STEP;
            wstart_d = i_WIDTH_START;
            wstep_d  = i_WIDTH_STEP;
            dcnt_d   = i_DELAY_COUNT;
            wcnt_d   = i_WIDTH_COUNT;
            mode_d   = i_MODE_TRIGGER;
            tmo_d    = i_TIMEOUT;
            att_d    = 32'd0;
            tmocnt_d = 32'd0;
            herr_d   = 5'd0;
            didx_d   = 16'd0;
            widx_d   = 16'd0;
            result_d = RES_OK;
            if ((i_DELAY_COUNT == 16'd0) || (i_WIDTH_COUNT == 16'd0)) begin
              state_d  = S_DONE;
              result_d = RES_CFG;
              done_d   = 1'b1;
              busy_d   = 1'b0;
              ctrl_d   = CTRL_STOP;
            end else begin
              state_d = S_LOAD;
              busy_d  = 1'b1;
              delay_d = i_DELAY_START;
              width_d = i_WIDTH_START;
              ctrl_d  = i_MODE_TRIGGER ? CTRL_RUN_TRIG : CTRL_RUN;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD: begin
          state_d = S_WRITE;
          wr_d    = 1'b1;
          att_d   = att_q + 32'd1;
        end
        S_WRITE: begin
          state_d = S_ARM;
          cnt_d   = 32'd0;
        end
        S_ARM: begin
          if (i_LOCK) begin
            state_d = S_RUN;
            cnt_d   = 32'd0;
          end else if (cnt_q == ARM_LAST) begin
            state_d  = S_DONE;
            herr_d   = i_HANDLER_STATUS;
            result_d = RES_REJECT;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            ctrl_d   = CTRL_STOP;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_RUN: begin
          if (!i_LOCK) begin
            state_d = S_SETTLE;
            cnt_d   = 32'd0;
          end else if ((tmo_q != 32'd0) && (cnt_q == (tmo_q - 32'd1))) begin
            state_d  = S_STOP_TMO;
            wr_d     = 1'b1;
            ctrl_d   = CTRL_STOP;
            tmocnt_d = tmocnt_q + 32'd1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_STOP_TMO: begin
          state_d = S_SETTLE;
          cnt_d   = 32'd0;
        end
        S_SETTLE: begin
          if (i_LOCK) begin
            cnt_d = 32'd0;
          end else if (cnt_q == SETTLE_LAST) begin
            if (widx_q == (wcnt_q - 16'd1)) begin
              if (didx_q == (dcnt_q - 16'd1)) begin
                state_d  = S_DONE;
                result_d = RES_OK;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                ctrl_d   = CTRL_STOP;
              end else begin
                state_d = S_LOAD;
                widx_d  = 16'd0;
                didx_d  = didx_q + 16'd1;
                delay_d = delay_q + dstep_q;
                width_d = wstart_q;
                ctrl_d  = mode_q ? CTRL_RUN_TRIG : CTRL_RUN;
              end
            end else begin
              state_d = S_LOAD;
              widx_d  = widx_q + 16'd1;
              width_d = width_q + wstep_q;
              ctrl_d  = mode_q ? CTRL_RUN_TRIG : CTRL_RUN;
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_ABT_GAP: begin
          state_d = S_STOP_ABT;
          wr_d    = 1'b1;
          ctrl_d  = CTRL_STOP;
        end
        S_STOP_ABT: begin
          state_d  = S_DONE;
          result_d = RES_ABORT;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          ctrl_d   = CTRL_STOP;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          ctrl_d  = CTRL_STOP;
        end
      endcase
    end
  end

  // State, latched sweep parameters and registered outputs.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= 32'd0;
      dstep_q  <= 32'd0;
      wstart_q <= 32'd0;
      wstep_q  <= 32'd0;
      dcnt_q   <= 16'd0;
      wcnt_q   <= 16'd0;
      mode_q   <= 1'b0;
      tmo_q    <= 32'd0;
      delay_q  <= 32'd0;
      width_q  <= 32'd0;
      ctrl_q   <= 8'h00;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 2'd0;
      herr_q   <= 5'd0;
      didx_q   <= 16'd0;
      widx_q   <= 16'd0;
      att_q    <= 32'd0;
      tmocnt_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dstep_q  <= dstep_d;
      wstart_q <= wstart_d;
      wstep_q  <= wstep_d;
      dcnt_q   <= dcnt_d;
      wcnt_q   <= wcnt_d;
      mode_q   <= mode_d;
      tmo_q    <= tmo_d;
      delay_q  <= delay_d;
      width_q  <= width_d;
      ctrl_q   <= ctrl_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      herr_q   <= herr_d;
      didx_q   <= didx_d;
      widx_q   <= widx_d;
      att_q    <= att_d;
      tmocnt_q <= tmocnt_d;
    end
  end

  assign o_DELAY_1ST   = delay_q;
  assign o_DELAY_2ND   = 32'd0;
  assign o_PULSE_WIDTH = width_q;
  assign o_CONTROL     = ctrl_q;
  assign o_CONTROL_WR  = wr_q;
  assign o_BUSY        = busy_q;
  assign o_DONE        = done_q;
  assign o_RESULT      = result_q;
  assign o_HANDLER_ERR = herr_q;
  assign o_DELAY_IDX   = didx_q;
  assign o_WIDTH_IDX   = widx_q;
  assign o_ATTEMPTS    = att_q;
  assign o_TIMEOUTS    = tmocnt_q;

endmodule
